multicycle_control: RTL

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/mips_pkg.sv | 13 +
 rtl/alu_decoder.sv | 18 +
 rtl/multicycle_control.sv | 86 ++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared state encodings, opcodes, funct codes and ALU control codes for the multicycle controller.
package mips_pkg;
  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3,
                         MEMWB = 4'd4, MEMWR = 4'd5, RTYPEEX = 4'd6, RTYPEWB = 4'd7,
                         BEQEX = 4'd8, ADDIEX = 4'd9, ADDIWB = 4'd10, JEX = 4'd11;
  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_RTYPE = 6'b000000,
                         OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100,
                         F_OR = 6'b100101, F_SLT = 6'b101010;
  localparam logic [2:0] ALU_ADD = 3'b010, ALU_SUB = 3'b110, ALU_AND = 3'b000,
                         ALU_OR = 3'b001, ALU_SLT = 3'b111;
  localparam logic [1:0] ALUOP_ADD = 2'b00, ALUOP_SUB = 2'b01, ALUOP_FUNCT = 2'b10;
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps aluOp (00 add, 01 sub, 10 funct) and funct to the 3-bit ALU control.
module alu_decoder
  import mips_pkg::*;
(
  input  logic [1:0] aluOp,
  input  logic [5:0] funct,
  output logic [2:0] aluControl
);
  logic [2:0] funct_ctl;
  always_comb begin
    funct_ctl = funct == F_SUB ? ALU_SUB :
                funct == F_AND ? ALU_AND :
                funct == F_OR  ? ALU_OR  :
                funct == F_SLT ? ALU_SLT : ALU_ADD;
    aluControl = aluOp == ALUOP_SUB ? ALU_SUB :
                 aluOp == ALUOP_FUNCT ? funct_ctl : ALU_ADD;
  end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore FSM controller for a multicycle MIPS datapath.
// Define MULTICYCLE_CTRL_ADDI_EN to add the addi path (ADDIEX/ADDIWB).
module multicycle_control
  import mips_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcEn,
  output logic       irWrite,
  output logic       memWrite,
  output logic       regWrite,
  output logic       iOrD,
  output logic       memtoReg,
  output logic       regDst,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] pcSrc,
  output logic [2:0] aluControl
);
  logic [STATE_W-1:0] state;
  logic [3:0] nxt;
  logic pc_write, branch, ir_we, mem_we, reg_we;
  logic [1:0] alu_op;

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= STATE_W'(FETCH);
    else state <= STATE_W'(nxt);

  always_comb begin
    nxt = FETCH;
    case (state)
      FETCH:   nxt = DECODE;
      DECODE:  nxt = (op == OP_LW || op == OP_SW) ? MEMADR :
                     op == OP_RTYPE ? RTYPEEX :
                     op == OP_BEQ ? BEQEX :
`ifdef MULTICYCLE_CTRL_ADDI_EN
                     op == OP_ADDI ? ADDIEX :
`endif
                     op == OP_J ? JEX : FETCH;
      MEMADR:  nxt = op == OP_LW ? MEMRD : MEMWR;
      MEMRD:   nxt = MEMWB;
      RTYPEEX: nxt = RTYPEWB;
`ifdef MULTICYCLE_CTRL_ADDI_EN
      ADDIEX:  nxt = ADDIWB;
`endif
      default: nxt = FETCH;
    endcase
  end

  always_comb begin
    {pc_write, branch, ir_we, mem_we, reg_we, iOrD, memtoReg, regDst, aluSrcA} = '0;
    aluSrcB = 2'b00;
    pcSrc = 2'b00;
    alu_op = ALUOP_ADD;
    case (state)
      FETCH:   begin aluSrcB = 2'b01; ir_we = 1'b1; pc_write = 1'b1; end
      DECODE:  aluSrcB = 2'b11;
      MEMADR:  begin aluSrcA = 1'b1; aluSrcB = 2'b10; end
      MEMRD:   iOrD = 1'b1;
      MEMWB:   begin reg_we = 1'b1; memtoReg = 1'b1; end
      MEMWR:   begin iOrD = 1'b1; mem_we = 1'b1; end
      RTYPEEX: begin aluSrcA = 1'b1; alu_op = ALUOP_FUNCT; end
      RTYPEWB: begin reg_we = 1'b1; regDst = 1'b1; end
      BEQEX:   begin aluSrcA = 1'b1; alu_op = ALUOP_SUB; pcSrc = 2'b01; branch = 1'b1; end
`ifdef MULTICYCLE_CTRL_ADDI_EN
      ADDIEX:  begin aluSrcA = 1'b1; aluSrcB = 2'b10; end
      ADDIWB:  reg_we = 1'b1;
`endif
      JEX:     begin pcSrc = 2'b10; pc_write = 1'b1; end
      default: ;
    endcase
  end

  // Reset already forces FETCH asynchronously; gating here kills FETCH's own enables too.
  assign pcEn = ~reset & (pc_write | (branch & zero));
  assign irWrite = ~reset & ir_we;
  assign memWrite = ~reset & mem_we;
  assign regWrite = ~reset & reg_we;

  alu_decoder u_alu_decoder (.aluOp(alu_op), .funct(funct), .aluControl(aluControl));
endmodule
